fdiv_arbiter: RTL
=================

// Module: fdiv_arbiter
// PURPOSE
//   Shares one pipelined fdiv unit (2-cycle latency, one issue per cycle, no stall)
//   among NREQ requesters. Round-robin arbitration picks one request per cycle.
//   A tag pipeline tracks which requester owns each in-flight operation.
//   Each quotient is routed back to its owner when it leaves the divider.
//   Sits between the FPU issue logic and the single fdiv instance.
// PARAMETERS
//   NREQ  2   number of requesters (>=2)
//   LAT   2   fdiv latency in cycles, from operands on div_a/div_b to result on div_q
//   IDW   1   requester id width, = $clog2(NREQ)
// PORTS
//   clk        in   1        clock, all state on rising edge
//   rst_n      in   1        asynchronous reset, active low
//   req_valid  in   NREQ     request i valid
//   req_a      in   NREQ*32  dividend, requester i at [32*i+:32]
//   req_b      in   NREQ*32  divisor,  requester i at [32*i+:32]
//   req_ready  out  NREQ     one-hot grant; request i accepted when req_valid[i]&req_ready[i]
//   div_a      out  32       dividend to fdiv
//   div_b      out  32       divisor to fdiv
//   div_q      in   32       quotient from fdiv
//   div_ovf    in   1        overflow from fdiv
//   resp_valid out  NREQ     one-hot; result for requester i this cycle
//   resp_q     out  32       quotient (shared bus, qualified by resp_valid)
//   resp_ovf   out  1        overflow flag, qualified by resp_valid
//   busy       out  1        at least one operation is in flight
//   inflight   out  $clog2(LAT+1)  number of operations in flight
// BEHAVIOUR
//   Reset: rr_ptr=0, all tag-pipe valids=0, resp_valid=0, resp_q=0, resp_ovf=0, busy=0, inflight=0.
//   Arbitration is combinational.
//     - grant = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... mod NREQ.
//     - req_ready = grant; it is all-zero when no request is valid.
//     - req_ready never asserts without req_valid.
//   Operand mux: div_a/div_b = operands of the granted requester; 0 when there is no grant.
//   Pointer update: on an issue, rr_ptr <= granted id + 1 (wraps NREQ-1 -> 0). Held otherwise.
//   Tag pipe: LAT stages of {v, id}.
//     - Stage 0 loads {issue, granted id}; stage k loads stage k-1.
//     - Shifts every cycle; the divider cannot stall.
//   Response: resp_valid, resp_q and resp_ovf are registered.
//     - When the last stage is valid: resp_valid[id] <= 1, resp_q <= div_q, resp_ovf <= div_ovf.
//     - Otherwise resp_valid <= 0 and resp_q/resp_ovf hold.
//     - Net latency is LAT+1 cycles from the accepting edge to resp_valid.
//   Responses have no backpressure. Requesters must accept a result in the cycle it is presented.
//   Throughput is one issue per cycle.
//     - When all NREQ requesters are continuously valid, grants rotate 0,1,...,NREQ-1,0.
//     - Each requester is granted at least once every NREQ cycles (no starvation).
//   inflight counter:
//     - +1 on issue, -1 when the last stage is valid, unchanged when both happen together.
//     - Never exceeds LAT. busy = (inflight != 0).
//   Boundaries:
//     - Requests arriving one cycle apart are each granted in their own cycle.
//     - A requester may issue back-to-back; results return in issue order.
//     - Reset mid-operation clears the tag pipe. In-flight results are discarded and no resp_valid follows.
//     - fdiv itself has no reset; any garbage in its pipeline is masked by the cleared tag valids.
//     - Dropping req_valid without a grant is legal; no state changes.
// STRUCTURE
//   Shared package fpu_pkg holds:
//     - FDIV_LAT = 2 (must match the fdiv pipeline depth);
//     - FP_W = 32;
//     - typedef tag_t {logic v; logic [IDW-1:0] id;}.
//   One sub-module: rr_arbiter (NREQ), with inputs req, ptr and output one-hot grant.
//   The tag pipe, operand mux, response registers and counter stay in this module.
//   fdiv is instantiated by the parent, not inside this block.
// TESTING (bench instantiates fdiv_arbiter + fdiv, NREQ=2, LAT=2)
//   1. Single issue: req0 a=0x40C00000 (6.0), b=0x40000000 (2.0)
//      -> req_ready[0]=1 that cycle; 3 edges later resp_valid=2'b01, resp_q=0x40400000 (3.0).
//   2. Contention: both valid in the same cycle after reset
//      - req0 = 1.0/4.0, req1 = 6.0/2.0
//      -> grant req0 then req1
//      -> resp 0x3E800000 to req0, then 0x40400000 to req1 on the next cycle.
//   3. Fairness: both requesters continuously valid for 8 cycles
//      -> grants alternate 01,10,01,...; four results each, in issue order; inflight peaks at 2.
//   4. Back-to-back from one requester: req1 issues 3 distinct divisions on consecutive cycles
//      -> 3 consecutive resp_valid=2'b10 with matching quotients; busy drops one cycle after the last.
//   5. Reset mid-flight: issue 2 ops, assert rst_n=0 one cycle later
//      -> resp_valid stays 0, inflight=0, rr_ptr=0; the next request after release completes normally.
//   6. Idle: no req_valid for 10 cycles
//      -> req_ready=0, div_a=div_b=0, resp_valid=0, busy=0.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU constants and the fdiv ownership tag carried alongside each in-flight divide.
package fpu_pkg;

  localparam int unsigned FDIV_LAT  = 2;   // must match the fdiv pipeline depth
  localparam int unsigned FP_W      = 32;
  localparam int unsigned FDIV_NREQ = 2;
  localparam int unsigned FDIV_IDW  = $clog2(FDIV_NREQ);

  // One tag-pipe stage: valid bit plus owning requester id.
  typedef struct packed {
    logic                v;
    logic [FDIV_IDW-1:0] id;
  } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after ptr.
module rr_arbiter #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant
);

  logic           found;
  logic [IDW-1:0] idx;

  // Search ptr, ptr+1, ... (mod NREQ) and grant the first valid request.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      idx = IDW'((32'(ptr) + off) % NREQ);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fdiv_arbiter.sv
// Shares one non-stalling pipelined fdiv among NREQ requesters; a tag pipe
// running in lockstep with the divider routes each quotient back to its owner.
module fdiv_arbiter
  import fpu_pkg::*;
#(
  parameter int unsigned NREQ = FDIV_NREQ,  // $clog2(NREQ) must equal FDIV_IDW
  parameter int unsigned LAT  = FDIV_LAT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*FP_W-1:0] req_a,
  input  logic [NREQ*FP_W-1:0] req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic [FP_W-1:0]      div_a,
  output logic [FP_W-1:0]      div_b,
  input  logic [FP_W-1:0]      div_q,
  input  logic                 div_ovf,
  output logic [NREQ-1:0]      resp_valid,
  output logic [FP_W-1:0]      resp_q,
  output logic                 resp_ovf,
  output logic                 busy,
  output logic [$clog2(LAT+1)-1:0] inflight
);

  localparam int unsigned IDW = FDIV_IDW;
  localparam int unsigned CW  = $clog2(LAT+1);

  logic [NREQ-1:0] grant;
  logic            issue;
  logic            retire;
  logic [IDW-1:0]  gnt_id;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  tag_t            tag_q [LAT];
  tag_t            tag_d [LAT];
  logic [NREQ-1:0] resp_valid_q, resp_valid_d;
  logic [FP_W-1:0] resp_q_q, resp_q_d;
  logic            resp_ovf_q, resp_ovf_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic            busy_q;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (grant)
  );

  // Grant encode and operand mux; operands are zero when nothing is granted.
  always_comb begin
    issue  = |grant;
    gnt_id = '0;
    div_a  = '0;
    div_b  = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (grant[i]) begin
        gnt_id = IDW'(i);
        div_a  = req_a[FP_W*i +: FP_W];
        div_b  = req_b[FP_W*i +: FP_W];
      end
    end
  end

  // Next state: pointer, tag pipe, response capture and in-flight count.
  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    resp_valid_d = '0;
    resp_q_d     = resp_q_q;
    resp_ovf_d   = resp_ovf_q;
    inflight_d   = inflight_q;
    retire       = tag_q[LAT-1].v;

    if (issue) begin
      rr_ptr_d = (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + 1'b1;
    end

    tag_d[0].v  = issue;
    tag_d[0].id = gnt_id;
    for (int k = 1; k < int'(LAT); k++) begin
      tag_d[k] = tag_q[k-1];
    end

    if (retire) begin
      resp_valid_d[tag_q[LAT-1].id] = 1'b1;
      resp_q_d                      = div_q;
      resp_ovf_d                    = div_ovf;
    end

    if (issue && !retire) begin
      inflight_d = inflight_q + CW'(1);
    end else if (!issue && retire) begin
      inflight_d = inflight_q - CW'(1);
    end
  end

  // State registers; reset drops every in-flight tag so stale fdiv output is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q     <= '0;
      for (int k = 0; k < int'(LAT); k++) begin
        tag_q[k] <= '0;
      end
      resp_valid_q <= '0;
      resp_q_q     <= '0;
      resp_ovf_q   <= 1'b0;
      inflight_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      for (int k = 0; k < int'(LAT); k++) begin
        tag_q[k] <= tag_d[k];
      end
      resp_valid_q <= resp_valid_d;
      resp_q_q     <= resp_q_d;
      resp_ovf_q   <= resp_ovf_d;
      inflight_q   <= inflight_d;
      busy_q       <= (inflight_d != '0);
    end
  end

  assign req_ready  = grant;
  assign resp_valid = resp_valid_q;
  assign resp_q     = resp_q_q;
  assign resp_ovf   = resp_ovf_q;
  assign inflight   = inflight_q;
  assign busy       = busy_q;

endmodule
